// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble/flush sequencing for the exec stage and its neighbours.
// Define PIPE_CTRL_PERF_EN to build the stallCycles/flushCount performance counters.
module pipe_hazard_ctrl #(
    parameter int FLUSH_DEPTH  = 2,
    parameter int MEM_WAIT_MAX = 16
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        pcSel,
    input  logic [1:0]  memOp,
    input  logic        memReady,
    input  logic [4:0]  exRd,
    input  logic        exIsLoad,
    input  logic [4:0]  idRs1,
    input  logic [4:0]  idRs2,
    input  logic        idUseRs1,
    input  logic        idUseRs2,
    output logic        stallFetch,
    output logic        stallDecode,
    output logic        stallExec,
    output logic        bubbleExec,
    output logic        flushDecode,
    output logic        memTimeout,
    output logic [1:0]  state,
    output logic [31:0] stallCycles,
    output logic [31:0] flushCount
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MEMWAIT = 2'b01,
        FLUSH   = 2'b10,
        LOADUSE = 2'b11
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX);
    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_DEPTH - 1);

    state_t     curState, nextState;
    logic [7:0] waitCnt, waitNext;
    logic [1:0] flushCnt, flushNext;
    logic       memPending;
    logic       loadUse;

    assign memPending = ((memOp == 2'b01) || (memOp == 2'b10)) && !memReady;
    assign loadUse    = exIsLoad && (exRd != 5'd0) &&
                        ((idUseRs1 && (idRs1 == exRd)) || (idUseRs2 && (idRs2 == exRd)));
    assign state      = curState;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            curState <= RUN;
            waitCnt  <= 8'd0;
            flushCnt <= 2'd0;
        end else begin
            curState <= nextState;
            waitCnt  <= waitNext;
            flushCnt <= flushNext;
        end
    end

    always_comb begin
        nextState   = curState;
        waitNext    = waitCnt;
        flushNext   = flushCnt;
        stallFetch  = 1'b0;
        stallDecode = 1'b0;
        stallExec   = 1'b0;
        bubbleExec  = 1'b0;
        flushDecode = 1'b0;
        memTimeout  = 1'b0;
        unique case (curState)
            RUN, LOADUSE: begin
                if (memPending) begin
                    stallFetch  = 1'b1;
                    stallDecode = 1'b1;
                    stallExec   = 1'b1;
                    waitNext    = 8'd1;
                    nextState   = MEMWAIT;
                end else if (pcSel) begin
                    flushDecode = 1'b1;
                    bubbleExec  = 1'b1;
                    nextState   = RUN;
                    if (FLUSH_DEPTH > 1) begin
                        flushNext = FLUSH_LOAD;
                        nextState = FLUSH;
                    end
                end else if ((curState == RUN) && loadUse) begin
                    stallFetch  = 1'b1;
                    stallDecode = 1'b1;
                    bubbleExec  = 1'b1;
                    nextState   = LOADUSE;
                end else begin
                    nextState = RUN;
                end
            end
            MEMWAIT: begin
                if (memReady) begin
                    // A redirect held behind the wait is honoured in the release cycle
                    waitNext  = 8'd0;
                    nextState = RUN;
                    if (pcSel) begin
                        flushDecode = 1'b1;
                        bubbleExec  = 1'b1;
                        if (FLUSH_DEPTH > 1) begin
                            flushNext = FLUSH_LOAD;
                            nextState = FLUSH;
                        end
                    end
                end else if (waitCnt == WAIT_LIMIT) begin
                    memTimeout = 1'b1;
                    waitNext   = 8'd0;
                    nextState  = RUN;
                end else begin
                    stallFetch  = 1'b1;
                    stallDecode = 1'b1;
                    stallExec   = 1'b1;
                    waitNext    = waitCnt + 8'd1;
                end
            end
            FLUSH: begin
                flushDecode = 1'b1;
                bubbleExec  = 1'b1;
                flushNext   = flushCnt - 2'd1;
                if (flushCnt == 2'd1) begin
                    nextState = RUN;
                end
            end
            default: begin
                nextState = RUN;
            end
        endcase
        // Outputs read as zero for the whole time reset is held, whatever the inputs do
        if (!resetN) begin
            stallFetch  = 1'b0;
            stallDecode = 1'b0;
            stallExec   = 1'b0;
            bubbleExec  = 1'b0;
            flushDecode = 1'b0;
            memTimeout  = 1'b0;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stallCnt;
    logic [31:0] flushEvents;

    // flushDecode outside FLUSH can only come from a redirect being accepted
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            stallCnt    <= 32'd0;
            flushEvents <= 32'd0;
        end else begin
            if (stallExec || stallDecode) begin
                stallCnt <= stallCnt + 32'd1;
            end
            if (flushDecode && (curState != FLUSH)) begin
                flushEvents <= flushEvents + 32'd1;
            end
        end
    end

    assign stallCycles = stallCnt;
    assign flushCount  = flushEvents;
`else
    assign stallCycles = 32'd0;
    assign flushCount  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: per-cycle expected control vectors queued with the
// stimulus and compared at the falling edge; counter expectations follow PIPE_CTRL_PERF_EN.
module tb_pipe_hazard_ctrl;

    localparam int FLUSH_DEPTH  = 3;
    localparam int MEM_WAIT_MAX = 4;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    // Expected vector layout: {stallFetch, stallDecode, stallExec, bubbleExec, flushDecode, memTimeout, state}
    localparam logic [7:0] IDLE           = 8'b000000_00;
    localparam logic [7:0] MEM_ENTER      = 8'b111000_00;
    localparam logic [7:0] MEM_HOLD       = 8'b111000_01;
    localparam logic [7:0] MEM_RELEASE    = 8'b000000_01;
    localparam logic [7:0] MEM_TIMEOUT    = 8'b000001_01;
    localparam logic [7:0] FLUSH_ENTER    = 8'b000110_00;
    localparam logic [7:0] FLUSH_HOLD     = 8'b000110_10;
    localparam logic [7:0] FLUSH_FROM_MEM = 8'b000110_01;
    localparam logic [7:0] FLUSH_FROM_LU  = 8'b000110_11;
    localparam logic [7:0] LU_HIT         = 8'b110100_00;
    localparam logic [7:0] LU_IDLE        = 8'b000000_11;

    logic        clk;
    logic        resetN;
    logic        pcSel;
    logic [1:0]  memOp;
    logic        memReady;
    logic [4:0]  exRd;
    logic        exIsLoad;
    logic [4:0]  idRs1;
    logic [4:0]  idRs2;
    logic        idUseRs1;
    logic        idUseRs2;
    logic        stallFetch;
    logic        stallDecode;
    logic        stallExec;
    logic        bubbleExec;
    logic        flushDecode;
    logic        memTimeout;
    logic [1:0]  state;
    logic [31:0] stallCycles;
    logic [31:0] flushCount;

    typedef struct packed {
        logic       ps;
        logic [1:0] mo;
        logic       mr;
        logic       ld;
        logic [4:0] rd;
        logic       u1;
        logic [4:0] r1;
        logic       u2;
        logic [4:0] r2;
        logic [7:0] exp;
    } stim_t;

    logic [7:0] expQ[$];
    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl #(
        .FLUSH_DEPTH (FLUSH_DEPTH),
        .MEM_WAIT_MAX(MEM_WAIT_MAX)
    ) dut (
        .clk        (clk),
        .resetN     (resetN),
        .pcSel      (pcSel),
        .memOp      (memOp),
        .memReady   (memReady),
        .exRd       (exRd),
        .exIsLoad   (exIsLoad),
        .idRs1      (idRs1),
        .idRs2      (idRs2),
        .idUseRs1   (idUseRs1),
        .idUseRs2   (idUseRs2),
        .stallFetch (stallFetch),
        .stallDecode(stallDecode),
        .stallExec  (stallExec),
        .bubbleExec (bubbleExec),
        .flushDecode(flushDecode),
        .memTimeout (memTimeout),
        .state      (state),
        .stallCycles(stallCycles),
        .flushCount (flushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(input logic ps, input logic [1:0] mo, input logic mr,
                                 input logic [7:0] exp);
        stim_t s;
        s     = '0;
        s.ps  = ps;
        s.mo  = mo;
        s.mr  = mr;
        s.exp = exp;
        return s;
    endfunction

    function automatic stim_t mkLu(input logic ld, input logic [4:0] rd, input logic u1,
                                   input logic [4:0] r1, input logic u2, input logic [4:0] r2,
                                   input logic [7:0] exp);
        stim_t s;
        s     = '0;
        s.ld  = ld;
        s.rd  = rd;
        s.u1  = u1;
        s.r1  = r1;
        s.u2  = u2;
        s.r2  = r2;
        s.exp = exp;
        return s;
    endfunction

    function automatic logic [7:0] observed();
        return {stallFetch, stallDecode, stallExec, bubbleExec, flushDecode, memTimeout, state};
    endfunction

    task automatic applyStimulus(input stim_t s);
        pcSel    = s.ps;
        memOp    = s.mo;
        memReady = s.mr;
        exIsLoad = s.ld;
        exRd     = s.rd;
        idUseRs1 = s.u1;
        idRs1    = s.r1;
        idUseRs2 = s.u2;
        idRs2    = s.r2;
        expQ.push_back(s.exp);
    endtask

    task automatic test_reset();
        logic [7:0] want, got;
        resetN = 1'b0;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(mk(1'b1, 2'b01, 1'b0, IDLE));
            @(negedge clk);
            want = expQ.pop_front();
            got  = observed();
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL reset[%0d] got %b expected %b", i, got, want);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (stallCycles !== 32'd0 || flushCount !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_counters got %0d/%0d expected 0/0", stallCycles, flushCount);
        end
        resetN = 1'b1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(mk(1'b0, (i == 0) ? 2'b01 : 2'b00, 1'b1, IDLE));
            @(negedge clk);
            want = expQ.pop_front();
            got  = observed();
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL reset_release[%0d] got %b expected %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        stim_t tbl[$];
        logic [7:0] want, got;
        tbl.push_back(mk(1'b0, 2'b01, 1'b0, MEM_ENTER));
        tbl.push_back(mk(1'b0, 2'b01, 1'b0, MEM_HOLD));
        tbl.push_back(mk(1'b0, 2'b01, 1'b0, MEM_HOLD));
        tbl.push_back(mk(1'b0, 2'b01, 1'b1, MEM_RELEASE));
        tbl.push_back(mk(1'b0, 2'b00, 1'b0, IDLE));
        foreach (tbl[i]) begin
            applyStimulus(tbl[i]);
            @(negedge clk);
            want = expQ.pop_front();
            got  = observed();
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL mem_wait[%0d] got %b expected %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        stim_t tbl[$];
        logic [7:0] want, got;
        tbl.push_back(mk(1'b0, 2'b01, 1'b0, MEM_ENTER));
        tbl.push_back(mk(1'b0, 2'b01, 1'b0, MEM_HOLD));
        tbl.push_back(mk(1'b0, 2'b01, 1'b0, MEM_HOLD));
        tbl.push_back(mk(1'b0, 2'b01, 1'b0, MEM_HOLD));
        tbl.push_back(mk(1'b0, 2'b01, 1'b0, MEM_TIMEOUT));
        tbl.push_back(mk(1'b0, 2'b00, 1'b0, IDLE));
        tbl.push_back(mk(1'b0, 2'b01, 1'b0, MEM_ENTER));
        tbl.push_back(mk(1'b0, 2'b01, 1'b0, MEM_HOLD));
        tbl.push_back(mk(1'b0, 2'b01, 1'b0, MEM_HOLD));
        foreach (tbl[i]) begin
            applyStimulus(tbl[i]);
            @(negedge clk);
            want = expQ.pop_front();
            got  = observed();
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL timeout[%0d] got %b expected %b", i, got, want);
            end
            @(posedge clk); #1;
        end
        // Reset lands mid-wait: outputs must drop at once with no timeout pulse
        resetN = 1'b0;
        applyStimulus(mk(1'b0, 2'b01, 1'b0, IDLE));
        #2;
        want = expQ.pop_front();
        got  = observed();
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL timeout_midreset got %b expected %b", got, want);
        end
        @(posedge clk); #1;
        resetN = 1'b1;
        applyStimulus(mk(1'b0, 2'b00, 1'b0, IDLE));
        @(negedge clk);
        want = expQ.pop_front();
        got  = observed();
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL timeout_after_reset got %b expected %b", got, want);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_redirect();
        stim_t tbl[$];
        logic [7:0] want, got;
        logic [31:0] wantFlush;
        tbl.push_back(mk(1'b1, 2'b00, 1'b0, FLUSH_ENTER));
        tbl.push_back(mk(1'b1, 2'b01, 1'b0, FLUSH_HOLD));
        tbl.push_back(mk(1'b0, 2'b00, 1'b0, FLUSH_HOLD));
        tbl.push_back(mk(1'b0, 2'b00, 1'b0, IDLE));
        foreach (tbl[i]) begin
            applyStimulus(tbl[i]);
            @(negedge clk);
            want = expQ.pop_front();
            got  = observed();
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL redirect[%0d] got %b expected %b", i, got, want);
            end
            @(posedge clk); #1;
        end
        wantFlush = PERF_ON ? 32'd1 : 32'd0;
        checks++;
        if (flushCount !== wantFlush) begin
            errors++;
            $display("[TB] FAIL redirect_flushCount got %0d expected %0d", flushCount, wantFlush);
        end
    endtask

    task automatic test_load_use();
        stim_t tbl[$];
        logic [7:0] want, got;
        tbl.push_back(mkLu(1'b1, 5'd5, 1'b0, 5'd3, 1'b1, 5'd5, LU_HIT));
        tbl.push_back(mkLu(1'b1, 5'd5, 1'b0, 5'd3, 1'b1, 5'd5, LU_IDLE));
        tbl.push_back(mkLu(1'b0, 5'd5, 1'b0, 5'd3, 1'b1, 5'd5, IDLE));
        tbl.push_back(mkLu(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, IDLE));
        tbl.push_back(mkLu(1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0, LU_HIT));
        tbl.push_back(mkLu(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, LU_IDLE));
        tbl.push_back(mkLu(1'b1, 5'd4, 1'b0, 5'd4, 1'b0, 5'd4, IDLE));
        foreach (tbl[i]) begin
            applyStimulus(tbl[i]);
            @(negedge clk);
            want = expQ.pop_front();
            got  = observed();
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL load_use[%0d] got %b expected %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_simultaneous();
        stim_t tbl[$];
        logic [7:0] want, got;
        logic [31:0] wantStall, wantFlush;
        tbl.push_back(mk(1'b1, 2'b10, 1'b0, MEM_ENTER));
        tbl.push_back(mk(1'b1, 2'b10, 1'b0, MEM_HOLD));
        tbl.push_back(mk(1'b1, 2'b10, 1'b1, FLUSH_FROM_MEM));
        tbl.push_back(mk(1'b0, 2'b00, 1'b0, FLUSH_HOLD));
        tbl.push_back(mk(1'b0, 2'b00, 1'b0, FLUSH_HOLD));
        tbl.push_back(mk(1'b0, 2'b00, 1'b0, IDLE));
        foreach (tbl[i]) begin
            applyStimulus(tbl[i]);
            @(negedge clk);
            want = expQ.pop_front();
            got  = observed();
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL simultaneous[%0d] got %b expected %b", i, got, want);
            end
            @(posedge clk); #1;
        end
        wantStall = PERF_ON ? 32'd4 : 32'd0;
        wantFlush = PERF_ON ? 32'd2 : 32'd0;
        checks++;
        if (stallCycles !== wantStall) begin
            errors++;
            $display("[TB] FAIL simultaneous_stallCycles got %0d expected %0d", stallCycles, wantStall);
        end
        checks++;
        if (flushCount !== wantFlush) begin
            errors++;
            $display("[TB] FAIL simultaneous_flushCount got %0d expected %0d", flushCount, wantFlush);
        end
    endtask

    task automatic test_back_to_back();
        stim_t tbl[$];
        logic [7:0] want, got;
        logic [31:0] wantStall, wantFlush;
        tbl.push_back(mk(1'b0, 2'b01, 1'b1, IDLE));
        tbl.push_back(mk(1'b0, 2'b01, 1'b0, MEM_ENTER));
        tbl.push_back(mk(1'b0, 2'b01, 1'b1, MEM_RELEASE));
        tbl.push_back(mk(1'b0, 2'b10, 1'b0, MEM_ENTER));
        tbl.push_back(mk(1'b0, 2'b10, 1'b1, MEM_RELEASE));
        tbl.push_back(mk(1'b0, 2'b11, 1'b0, IDLE));
        tbl.push_back(mkLu(1'b1, 5'd9, 1'b1, 5'd9, 1'b0, 5'd0, LU_HIT));
        tbl.push_back(mk(1'b1, 2'b00, 1'b0, FLUSH_FROM_LU));
        tbl.push_back(mk(1'b0, 2'b00, 1'b0, FLUSH_HOLD));
        tbl.push_back(mk(1'b0, 2'b00, 1'b0, FLUSH_HOLD));
        tbl.push_back(mk(1'b0, 2'b00, 1'b0, IDLE));
        foreach (tbl[i]) begin
            applyStimulus(tbl[i]);
            @(negedge clk);
            want = expQ.pop_front();
            got  = observed();
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL back_to_back[%0d] got %b expected %b", i, got, want);
            end
            @(posedge clk); #1;
        end
        wantStall = PERF_ON ? 32'd7 : 32'd0;
        wantFlush = PERF_ON ? 32'd3 : 32'd0;
        checks++;
        if (stallCycles !== wantStall) begin
            errors++;
            $display("[TB] FAIL back_to_back_stallCycles got %0d expected %0d", stallCycles, wantStall);
        end
        checks++;
        if (flushCount !== wantFlush) begin
            errors++;
            $display("[TB] FAIL back_to_back_flushCount got %0d expected %0d", flushCount, wantFlush);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before the test sequence ended");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        resetN   = 1'b0;
        pcSel    = 1'b0;
        memOp    = 2'b00;
        memReady = 1'b0;
        exRd     = 5'd0;
        exIsLoad = 1'b0;
        idRs1    = 5'd0;
        idRs2    = 5'd0;
        idUseRs1 = 1'b0;
        idUseRs2 = 1'b0;
        test_reset();
        test_mem_wait();
        test_timeout();
        test_redirect();
        test_load_use();
        test_simultaneous();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
